pwm_gen: RTL and testbench

Converts the 10-bit frequency setpoint `freq` produced by the HMI block into the square-wave drive on the `pwm` pin of the VFD board. It is the consuming end of the `freq` interface: HMI writes `freq`, and this block reads and realises it. It uses an exact modulo-1,000,000 phase accumulator advanced by the 1 µs tick `pluse_us` from the clock/reset block, so the long-run output frequency equals `freq` in Hz. Setpoint changes are applied only at period boundaries, so the output never glitches.

---
 rtl/pwm_gen_if.sv | 11 +
 rtl/pwm_gen.sv | 89 ++++++++
 tb/tb_pwm_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_gen_if.sv
// Frequency setpoint / PWM drive bundle between the HMI side (master) and pwm_gen (slave).
interface pwm_gen_if;
   logic       pluse_us;
   logic [9:0] freq;
   logic       pwm;
   logic       period_done;
   logic       running;

   modport master (output pluse_us, freq, input pwm, period_done, running);
   modport slave  (input pluse_us, freq, output pwm, period_done, running);
endinterface

// File: rtl/pwm_gen.sv
// Square-wave generator driven by an exact modulo-MOD phase accumulator advanced on each 1 us tick.
// Setpoint changes are latched only at accumulator wrap, so periods never glitch.
module pwm_gen #(
   parameter int MOD      = 1000000,
   parameter int DUTY_PCT = 50,
   parameter int FREQ_MAX = 1000
) (
   input  logic     clk_sys,
   input  logic     rst_n,
   pwm_gen_if.slave bus
);
   localparam int ACC_W = $clog2(MOD + FREQ_MAX);
   localparam int TH    = MOD * DUTY_PCT / 100;
   localparam logic [ACC_W:0] MOD_V  = MOD[ACC_W:0];
   localparam logic [ACC_W:0] TH_V   = TH[ACC_W:0];
   localparam logic [9:0]     FMAX_V = FREQ_MAX[9:0];

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [9:0]       freq_lat;
   logic             pwm_q;
   logic             done_q;
   logic             run_q;

   logic [9:0]       freq_eff;
   logic [ACC_W:0]   sum;
   logic [ACC_W:0]   acc_nxt;
   logic             wrap;

   function automatic logic [9:0] sat_freq(input logic [9:0] f);
      return (f > FMAX_V) ? FMAX_V : f;
   endfunction

   // FREQ_MAX < MOD, so one subtraction per tick always brings the phase back below MOD.
   always_comb begin
      freq_eff = sat_freq(bus.freq);
      sum      = {1'b0, acc} + {{(ACC_W-9){1'b0}}, freq_lat};
      wrap     = (sum >= MOD_V);
      acc_nxt  = wrap ? (sum - MOD_V) : sum;
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= '0;
         freq_lat <= '0;
         pwm_q    <= 1'b0;
         done_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.pluse_us) begin
            case (state)
               IDLE: begin
                  if (freq_eff != '0) begin
                     freq_lat <= freq_eff;
                     acc      <= '0;
                     pwm_q    <= (TH_V != '0);
                     run_q    <= 1'b1;
                     state    <= RUN;
                  end
               end
               RUN: begin
                  if (wrap) begin
                     done_q   <= 1'b1;
                     freq_lat <= freq_eff;
                  end
                  if (wrap && freq_eff == '0) begin
                     acc   <= '0;
                     pwm_q <= 1'b0;
                     run_q <= 1'b0;
                     state <= IDLE;
                  end else begin
                     acc   <= acc_nxt[ACC_W-1:0];
                     pwm_q <= (acc_nxt < TH_V);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.pwm         = pwm_q;
   assign bus.period_done = done_q;
   assign bus.running     = run_q;
endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: default instance (MOD=1e6) plus a MOD=10000 instance for the low-frequency case.
module tb_pwm_gen;
   logic clk_sys;
   logic rst_n;

   pwm_gen_if bm();
   pwm_gen_if bs();

   pwm_gen u_dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .bus     (bm)
   );

   pwm_gen #(.MOD(10000), .DUTY_PCT(50), .FREQ_MAX(1000)) u_small (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .bus     (bs)
   );

   int errors = 0;
   int checks = 0;
   int tcount = 0;
   int exp_q[$];

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      bm.pluse_us = 1'b1;
      bs.pluse_us = 1'b1;
      @(negedge clk_sys);
      tcount++;
   endtask

   task automatic gap(input int n);
      bm.pluse_us = 1'b0;
      bs.pluse_us = 1'b0;
      repeat (n) @(negedge clk_sys);
   endtask

   // Ticks until a period_done is seen or the budget runs out; highs counts pwm over the period.
   task automatic run_until_wrap(input bit sel, input int limit,
                                 output int ticks, output int highs, output bit got);
      ticks = 0;
      got   = 1'b0;
      highs = int'(sel ? bs.pwm : bm.pwm);
      while (!got && ticks < limit) begin
         tick();
         ticks++;
         if ((sel ? bs.period_done : bm.period_done) === 1'b1) got = 1'b1;
         else highs += int'(sel ? bs.pwm : bm.pwm);
      end
   endtask

   task automatic test_reset();
      int act;
      rst_n = 1'b0;
      bm.freq = '0; bs.freq = '0;
      bm.pluse_us = 1'b0; bs.pluse_us = 1'b0;
      repeat (3) @(negedge clk_sys);
      checks++; if (bm.pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%b exp=0", bm.pwm); end
      checks++; if (bm.period_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bm.period_done); end
      checks++; if (bm.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", bm.running); end
      rst_n = 1'b1;
      act = 0;
      repeat (5000) begin
         tick();
         act += int'(bm.pwm | bm.period_done | bm.running | bs.pwm | bs.period_done | bs.running);
      end
      checks++; if (act !== 0) begin errors++; $display("FAIL idle_activity got=%0d exp=0", act); end
   endtask

   task automatic test_freq_1000();
      int tk, hi, e, t0, act;
      bit got;
      bm.freq = 10'd1000;
      tick();
      checks++; if (bm.running !== 1'b1) begin errors++; $display("FAIL f1000_start_running got=%b exp=1", bm.running); end
      checks++; if (bm.pwm !== 1'b1) begin errors++; $display("FAIL f1000_start_pwm got=%b exp=1", bm.pwm); end
      t0 = tcount;
      for (int i = 1; i <= 4; i++) exp_q.push_back(t0 + 1000 * i);
      for (int p = 0; p < 3; p++) begin
         run_until_wrap(1'b0, 1100, tk, hi, got);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
         checks++; if (got !== 1'b1) begin errors++; $display("FAIL f1000_wrap_seen p=%0d got=%b exp=1", p, got); end
         checks++; if (tcount !== e) begin errors++; $display("FAIL f1000_wrap_tick p=%0d got=%0d exp=%0d", p, tcount, e); end
         checks++; if (hi !== 500) begin errors++; $display("FAIL f1000_high p=%0d got=%0d exp=500", p, hi); end
         if (p == 1) begin
            gap(20);
            checks++; if (bm.period_done !== 1'b0) begin errors++; $display("FAIL freeze_done got=%b exp=0", bm.period_done); end
            checks++; if (bm.pwm !== 1'b1) begin errors++; $display("FAIL freeze_pwm got=%b exp=1", bm.pwm); end
         end
      end
      bm.freq = '0;
      run_until_wrap(1'b0, 1100, tk, hi, got);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (tcount !== e) begin errors++; $display("FAIL f1000_stop_tick got=%0d exp=%0d", tcount, e); end
      checks++; if (bm.running !== 1'b0 || bm.pwm !== 1'b0) begin errors++; $display("FAIL f1000_stop_idle running=%b pwm=%b exp=0/0", bm.running, bm.pwm); end
      act = 0;
      repeat (10) begin tick(); act += int'(bm.pwm | bm.running | bm.period_done); end
      checks++; if (act !== 0) begin errors++; $display("FAIL f1000_after_stop got=%0d exp=0", act); end
   endtask

   task automatic test_clamp();
      int tk, hi, e, t0;
      bit got;
      bm.freq = 10'd1023;
      tick();
      checks++; if (bm.running !== 1'b1) begin errors++; $display("FAIL clamp_running got=%b exp=1", bm.running); end
      t0 = tcount;
      for (int i = 1; i <= 3; i++) exp_q.push_back(t0 + 1000 * i);
      for (int p = 0; p < 2; p++) begin
         run_until_wrap(1'b0, 1100, tk, hi, got);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
         checks++; if (tcount !== e) begin errors++; $display("FAIL clamp_wrap_tick p=%0d got=%0d exp=%0d", p, tcount, e); end
         checks++; if (hi !== 500) begin errors++; $display("FAIL clamp_high p=%0d got=%0d exp=500", p, hi); end
      end
      bm.freq = '0;
      run_until_wrap(1'b0, 1100, tk, hi, got);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (tcount !== e) begin errors++; $display("FAIL clamp_stop_tick got=%0d exp=%0d", tcount, e); end
   endtask

   task automatic test_setpoint_change();
      int tk, hi, e, t0, act;
      bit got;
      bm.freq = 10'd100;
      tick();
      t0 = tcount;
      exp_q.push_back(t0 + 10000);
      run_until_wrap(1'b0, 10100, tk, hi, got);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (tcount !== e) begin errors++; $display("FAIL chg_first_wrap got=%0d exp=%0d", tcount, e); end
      run_until_wrap(1'b0, 4000, tk, hi, got);
      checks++; if (got !== 1'b0) begin errors++; $display("FAIL chg_early_wrap got=%b exp=0", got); end
      bm.freq = 10'd200;
      exp_q.push_back(t0 + 20000);
      exp_q.push_back(t0 + 25000);
      run_until_wrap(1'b0, 6100, tk, hi, got);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (tcount !== e) begin errors++; $display("FAIL chg_old_period got=%0d exp=%0d", tcount, e); end
      run_until_wrap(1'b0, 5100, tk, hi, got);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (tcount !== e) begin errors++; $display("FAIL chg_new_period got=%0d exp=%0d", tcount, e); end
      checks++; if (hi !== 2500) begin errors++; $display("FAIL chg_new_high got=%0d exp=2500", hi); end
      repeat (2000) tick();
      bm.freq = '0;
      exp_q.push_back(t0 + 30000);
      run_until_wrap(1'b0, 3100, tk, hi, got);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (tcount !== e) begin errors++; $display("FAIL chg_zero_completes got=%0d exp=%0d", tcount, e); end
      checks++; if (bm.running !== 1'b0 || bm.pwm !== 1'b0) begin errors++; $display("FAIL chg_zero_idle running=%b pwm=%b exp=0/0", bm.running, bm.pwm); end
      act = 0;
      repeat (1000) begin tick(); act += int'(bm.pwm | bm.running | bm.period_done); end
      checks++; if (act !== 0) begin errors++; $display("FAIL chg_zero_stays_idle got=%0d exp=0", act); end
   endtask

   // Small instance (modulus 10000) at freq=3: phases 0,2,1,0 give spacings 3334,3333,3333 and highs 1667,1666,1667.
   task automatic test_small_f3();
      int tk, hi, e, t0;
      int exp_hi[3] = '{1667, 1666, 1667};
      bit got;
      bs.freq = 10'd3;
      tick();
      checks++; if (bs.running !== 1'b1) begin errors++; $display("FAIL f3_running got=%b exp=1", bs.running); end
      t0 = tcount;
      exp_q.push_back(t0 + 3334);
      exp_q.push_back(t0 + 6667);
      exp_q.push_back(t0 + 10000);
      exp_q.push_back(t0 + 13334);
      for (int p = 0; p < 3; p++) begin
         run_until_wrap(1'b1, 3400, tk, hi, got);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
         checks++; if (tcount !== e) begin errors++; $display("FAIL f3_wrap_tick p=%0d got=%0d exp=%0d", p, tcount, e); end
         checks++; if (tk != 3333 && tk != 3334) begin errors++; $display("FAIL f3_spacing p=%0d got=%0d exp=3333|3334", p, tk); end
         checks++; if (hi !== exp_hi[p]) begin errors++; $display("FAIL f3_high p=%0d got=%0d exp=%0d", p, hi, exp_hi[p]); end
      end
      bs.freq = '0;
      run_until_wrap(1'b1, 3400, tk, hi, got);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (tcount !== e) begin errors++; $display("FAIL f3_stop_tick got=%0d exp=%0d", tcount, e); end
      checks++; if (bs.running !== 1'b0) begin errors++; $display("FAIL f3_stop_running got=%b exp=0", bs.running); end
   endtask

   task automatic test_reset_mid_run();
      int tk, hi, e, t0;
      bit got;
      bm.freq = 10'd1000;
      repeat (101) tick();
      checks++; if (bm.pwm !== 1'b1) begin errors++; $display("FAIL midrst_pre_pwm got=%b exp=1", bm.pwm); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bm.pwm !== 1'b0) begin errors++; $display("FAIL midrst_pwm got=%b exp=0", bm.pwm); end
      checks++; if (bm.running !== 1'b0) begin errors++; $display("FAIL midrst_running got=%b exp=0", bm.running); end
      checks++; if (u_dut.acc !== '0) begin errors++; $display("FAIL midrst_acc got=%0d exp=0", u_dut.acc); end
      @(negedge clk_sys);
      rst_n = 1'b1;
      tick();
      checks++; if (bm.running !== 1'b1 || bm.pwm !== 1'b1) begin errors++; $display("FAIL midrst_restart running=%b pwm=%b exp=1/1", bm.running, bm.pwm); end
      t0 = tcount;
      exp_q.push_back(t0 + 1000);
      run_until_wrap(1'b0, 1100, tk, hi, got);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (tcount !== e) begin errors++; $display("FAIL midrst_first_wrap got=%0d exp=%0d", tcount, e); end
      bm.freq = '0;
      run_until_wrap(1'b0, 1100, tk, hi, got);
      checks++; if (bm.running !== 1'b0) begin errors++; $display("FAIL midrst_stop got=%b exp=0", bm.running); end
   endtask

   initial begin
      test_reset();
      test_freq_1000();
      test_clamp();
      test_setpoint_change();
      test_small_f3();
      test_reset_mid_run();
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
